// File: rtl/exec_unit.sv
// Execute stage behind the 16x16 register bank: ALU ops in one cycle,
// MUL/DIV/MOD iterate one bit per cycle; result drives the bank write port.
//   in : clk, rst (sync, active-high), start, opcode, op_a, op_b, dest_in
//   out: busy, done, rw, dataOut, dest, zero, carry
module exec_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            opcode,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  busy,
  output logic                  done,
  output logic                  rw,
  output logic [WIDTH-1:0]      dataOut,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  zero,
  output logic                  carry
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]         cnt_q;
  logic [3:0]            op_q;
  logic [WIDTH-1:0]      a_q, b_q;
  logic [REG_ADDR_W-1:0] dst_q;
  // MUL: {hi,lo} is the product shift register (lo starts as b).
  // DIV/MOD: hi is the partial remainder, lo shifts dividend out
  // and quotient bits in.
  logic [WIDTH-1:0]      hi_q, lo_q;

  logic                  done_q, rw_q, zero_q, carry_q;
  logic [WIDTH-1:0]      data_q;
  logic [REG_ADDR_W-1:0] dest_q;

  logic                  is_iter;
  logic [WIDTH:0]        mul_sum;
  logic [WIDTH:0]        div_sh;
  logic [WIDTH+1:0]      div_tr;
  logic                  div_ge;
  logic [WIDTH:0]        sum, dif;
  logic [WIDTH-1:0]      res;
  logic                  res_c, res_v;

  assign is_iter = (opcode == OP_MUL) || (opcode == OP_DIV)
                || (opcode == OP_MOD);

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_tr  = {1'b0, div_sh} - {2'b00, b_q};
  assign div_ge  = ~div_tr[WIDTH+1];

  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign dif = {1'b0, a_q} - {1'b0, b_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = is_iter ? S_ITER : S_DONE;
      S_ITER: if (cnt_q == CW'(WIDTH-1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b1;
    unique case (op_q)
      OP_ADD: begin res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
      OP_SUB: begin res = dif[WIDTH-1:0]; res_c = dif[WIDTH]; end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      OP_SHL: res = a_q << b_q[3:0];
      OP_SHR: res = a_q >> b_q[3:0];
      OP_MUL: begin res = lo_q; res_c = |hi_q; end
      OP_DIV: begin res = lo_q; res_c = (b_q == '0); end
      OP_MOD: begin res = hi_q; res_c = (b_q == '0); end
      default: res_v = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rw_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            a_q   <= op_a;
            b_q   <= op_b;
            dst_q <= dest_in;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= (opcode == OP_MUL) ? op_b : op_a;
          end
        end
        S_ITER: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_q <= div_ge ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], div_ge};
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          // Reserved opcodes complete the handshake but leave the
          // write port and flags untouched.
          if (res_v) begin
            rw_q    <= 1'b1;
            data_q  <= res;
            dest_q  <= dst_q;
            zero_q  <= (res == '0);
            carry_q <= res_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign rw      = rw_q;
  assign dataOut = data_q;
  assign dest    = dest_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vectors, random ops
// against a behavioural model, handshake and reset corner cases.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  opcode;
  logic [15:0] op_a, op_b;
  logic [3:0]  dest_in;
  logic        busy, done, rw, zero, carry;
  logic [15:0] dataOut;
  logic [3:0]  dest;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_data;
  logic [3:0]  exp_dest;
  logic        exp_zero, exp_carry;

  exec_unit #(.WIDTH(16), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .dest_in(dest_in),
    .busy(busy), .done(done), .rw(rw), .dataOut(dataOut),
    .dest(dest), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, output logic [15:0] r,
                       output logic c, output logic v);
    longint p;
    v = 1'b1; c = 1'b0; r = '0;
    case (op)
      4'd0: begin p = longint'(a) + longint'(b); r = p[15:0]; c = (p > 65535); end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin p = longint'(a) * (longint'(1) << b[3:0]); r = p[15:0]; end
      4'd7: r = 16'(int'(a) / (1 << b[3:0]));
      4'd8: begin p = longint'(a) * longint'(b); r = p[15:0]; c = (p > 65535); end
      4'd9: begin
        if (b == 0) begin r = 16'hFFFF; c = 1'b1; end
        else r = a / b;
      end
      4'd10: begin
        if (b == 0) begin r = a; c = 1'b1; end
        else r = a % b;
      end
      default: v = 1'b0;
    endcase
  endtask

  // Drives one start pulse, then waits (bounded) for done.
  // Entered and left #1 after a rising edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d,
                       output int lat, output int busy_n,
                       output int rw_n);
    start = 1'b1; opcode = op; op_a = a; op_b = b; dest_in = d;
    @(posedge clk); #1;
    start = 1'b0;
    opcode = 4'($urandom); op_a = 16'($urandom);
    op_b = 16'($urandom); dest_in = 4'($urandom);
    lat = -1; busy_n = 0; rw_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (busy) busy_n++;
      if (rw) rw_n++;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = '0;
    op_a = '0; op_b = '0; dest_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rw, zero, carry, dataOut, dest} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b rw=%b z=%b c=%b data=%h dest=%h, want all 0",
               busy, done, rw, zero, carry, dataOut, dest);
    end
    rst = 1'b0;
    exp_data = '0; exp_dest = '0; exp_zero = 1'b0; exp_carry = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [3:0]  d;
    logic [15:0] r;
    logic        c;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    int lat, bn, rn, el;
    v[0]  = '{4'd0,  16'hFFFF, 16'h0001, 4'd3,  16'h0000, 1'b1};
    v[1]  = '{4'd1,  16'h0005, 16'h0007, 4'd4,  16'hFFFE, 1'b1};
    v[2]  = '{4'd8,  16'h0100, 16'h0100, 4'd5,  16'h0000, 1'b1};
    v[3]  = '{4'd8,  16'h00FF, 16'h0003, 4'd6,  16'h02FD, 1'b0};
    v[4]  = '{4'd9,  16'd100,  16'd7,    4'd7,  16'h000E, 1'b0};
    v[5]  = '{4'd10, 16'd100,  16'd7,    4'd8,  16'h0002, 1'b0};
    v[6]  = '{4'd9,  16'h1234, 16'h0000, 4'd9,  16'hFFFF, 1'b1};
    v[7]  = '{4'd10, 16'h1234, 16'h0000, 4'd10, 16'h1234, 1'b1};
    v[8]  = '{4'd6,  16'h0001, 16'h000F, 4'd11, 16'h8000, 1'b0};
    v[9]  = '{4'd7,  16'h8001, 16'h0010, 4'd12, 16'h8001, 1'b0};
    v[10] = '{4'd5,  16'h00FF, 16'h0000, 4'd13, 16'hFF00, 1'b0};
    v[11] = '{4'd7,  16'h8000, 16'h000F, 4'd14, 16'h0001, 1'b0};
    foreach (v[i]) begin
      el = (v[i].op >= 8) ? 17 : 1;
      issue(v[i].op, v[i].a, v[i].b, v[i].d, lat, bn, rn);
      checks++;
      if (lat !== el || bn !== el || rn !== 1) begin
        errors++;
        $display("FAIL dir%0d_timing: got lat=%0d busy=%0d rw=%0d, want lat=%0d busy=%0d rw=1",
                 i, lat, bn, rn, el, el);
      end
      checks++;
      if (dataOut !== v[i].r || dest !== v[i].d || carry !== v[i].c
          || zero !== (v[i].r == 0)) begin
        errors++;
        $display("FAIL dir%0d_result: got data=%h dest=%0d c=%b z=%b, want data=%h dest=%0d c=%b z=%b",
                 i, dataOut, dest, carry, zero, v[i].r, v[i].d, v[i].c, v[i].r == 0);
      end
      exp_data = v[i].r; exp_dest = v[i].d;
      exp_carry = v[i].c; exp_zero = (v[i].r == 0);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op, d;
    logic [15:0] a, b, r;
    logic        c, vld;
    int lat, bn, rn, el;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      d  = 4'($urandom);
      model(op, a, b, r, c, vld);
      if (vld) begin
        exp_data = r; exp_dest = d; exp_carry = c; exp_zero = (r == 0);
      end
      el = (op >= 8 && op <= 10) ? 17 : 1;
      issue(op, a, b, d, lat, bn, rn);
      checks++;
      if (lat !== el || bn !== el || rn !== int'(vld)) begin
        errors++;
        $display("FAIL rnd%0d_timing op=%0d: got lat=%0d busy=%0d rw=%0d, want lat=%0d busy=%0d rw=%0d",
                 i, op, lat, bn, rn, el, el, vld);
      end
      checks++;
      if (dataOut !== exp_data || dest !== exp_dest
          || carry !== exp_carry || zero !== exp_zero) begin
        errors++;
        $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got data=%h dest=%0d c=%b z=%b, want data=%h dest=%0d c=%b z=%b",
                 i, op, a, b, dataOut, dest, carry, zero,
                 exp_data, exp_dest, exp_carry, exp_zero);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn, rn;
    issue(4'd0, 16'd10, 16'd20, 4'd1, lat, bn, rn);
    issue(4'd1, 16'd50, 16'd8, 4'd2, lat, bn, rn);
    checks++;
    if (lat !== 1 || dataOut !== 16'd42 || dest !== 4'd2 || carry !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: got lat=%0d data=%h dest=%0d c=%b, want lat=1 data=002a dest=2 c=0",
               lat, dataOut, dest, carry);
    end
    exp_data = 16'd42; exp_dest = 4'd2; exp_carry = 1'b0; exp_zero = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int dones, first;
    start = 1'b1; opcode = 4'd8; op_a = 16'h00FF; op_b = 16'h0003; dest_in = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; first = -1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (done) begin
        dones++;
        if (first < 0) begin
          first = c;
          exp_data = dataOut; exp_dest = dest;
          exp_carry = carry; exp_zero = zero;
        end
      end
      start = 1'b0;
      if (c == 4 || c == 16) begin
        start = 1'b1; opcode = 4'd0; op_a = 16'd1; op_b = 16'd1; dest_in = 4'd2;
      end
    end
    checks++;
    if (dones !== 1 || first !== 17) begin
      errors++;
      $display("FAIL busy_ignore_timing: got dones=%0d first=%0d, want dones=1 first=17",
               dones, first);
    end
    checks++;
    if (exp_data !== 16'h02FD || exp_dest !== 4'd7 || exp_carry !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_result: got data=%h dest=%0d c=%b, want data=02fd dest=7 c=0",
               exp_data, exp_dest, exp_carry);
    end
    exp_data = 16'h02FD; exp_dest = 4'd7; exp_carry = 1'b0; exp_zero = 1'b0;
  endtask

  task automatic test_reserved();
    int lat, bn, rn;
    for (int op = 11; op < 16; op++) begin
      issue(4'(op), 16'($urandom), 16'($urandom), 4'($urandom), lat, bn, rn);
      checks++;
      if (lat !== 1 || rn !== 0 || dataOut !== exp_data || dest !== exp_dest
          || carry !== exp_carry || zero !== exp_zero) begin
        errors++;
        $display("FAIL reserved_op%0d: got lat=%0d rw=%0d data=%h dest=%0d c=%b z=%b, want lat=1 rw=0 data=%h dest=%0d c=%b z=%b",
                 op, lat, rn, dataOut, dest, carry, zero,
                 exp_data, exp_dest, exp_carry, exp_zero);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn, rn, rws;
    issue(4'd1, 16'h0005, 16'h0007, 4'd9, lat, bn, rn);
    start = 1'b1; opcode = 4'd8; op_a = 16'h0100; op_b = 16'h0100; dest_in = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    rws = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (rw) rws++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (rw) rws++;
    checks++;
    if ({busy, done, rw, zero, carry, dataOut, dest} !== '0 || rws !== 0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b rw=%b z=%b c=%b data=%h dest=%h rw_pulses=%0d, want all 0",
               busy, done, rw, zero, carry, dataOut, dest, rws);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_idle: got busy=%b done=%b data=%h, want 0 0 0000",
               busy, done, dataOut);
    end
    issue(4'd0, 16'd2, 16'd3, 4'd1, lat, bn, rn);
    checks++;
    if (lat !== 1 || rn !== 1 || dataOut !== 16'h0005 || dest !== 4'd1
        || carry !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_add: got lat=%0d rw=%0d data=%h dest=%0d c=%b z=%b, want 1 1 0005 1 0 0",
               lat, rn, dataOut, dest, carry, zero);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_while_busy();
    test_reserved();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
